// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared types and constants for the CPU inter-stage pipeline registers
package cpu_pipe_pkg;

    localparam logic [31:0] BUBBLE_PC_DEFAULT = 32'hffff_ffff;

    typedef struct packed {
        logic [31:0] pc;
        logic        regwrite;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } stage_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occupancy_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter with synchronous clear
module pipe_sat_counter
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    // count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              DATA_W    = 32,
    parameter int              RD_W      = 5,
    parameter int              SKID      = 1,
    parameter logic [PC_W-1:0] BUBBLE_PC = PC_W'(BUBBLE_PC_DEFAULT),
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_regwrite,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_regwrite,
    output logic [DATA_W-1:0] out_wdata,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              regwrite;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } payload_t;

    occupancy_t state, state_nx;
    payload_t   head, head_nx, skid, skid_nx, in_p;
    logic       rdy_q, in_fire, out_fire;

    assign in_p      = {in_pc, in_regwrite, in_wdata, in_rd};
    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // occupancy transitions; without a skid entry HALF never sees accept-without-drain, so FULL is unreachable
    always_comb begin
        state_nx = state;
        head_nx  = head;
        skid_nx  = skid;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    head_nx  = in_p;
                    state_nx = HALF;
                end
            end
            HALF: begin
                if (in_fire && out_fire)
                    head_nx = in_p;
                else if (in_fire) begin
                    skid_nx  = in_p;
                    state_nx = FULL;
                end else if (out_fire)
                    state_nx = EMPTY;
            end
            FULL: begin
                if (out_fire) begin
                    head_nx  = skid;
                    state_nx = HALF;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (flush)
            state_nx = EMPTY;
    end

    // state, payload and the registered ready flag that breaks the out_ready -> in_ready path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nx;
            head  <= head_nx;
            skid  <= skid_nx;
            rdy_q <= (state_nx != FULL);
        end
    end

    assign out_pc       = out_valid ? head.pc : BUBBLE_PC;
    assign out_wdata    = out_valid ? head.wdata : '0;
    assign out_rd       = out_valid ? head.rd : '0;
    assign out_regwrite = out_valid && head.regwrite && (head.rd != '0);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .clear (1'b0),
        .cnt   (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of the skid stage and a no-skid, 4-bit-counter variant
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, in_regwrite, out_valid, out_ready, out_regwrite;
    logic [31:0] in_pc, in_wdata, out_pc, out_wdata;
    logic [4:0]  in_rd, out_rd;
    logic [15:0] stall_cycles;

    logic        flush4, in_valid4, in_ready4, in_regwrite4, out_valid4, out_ready4, out_regwrite4;
    logic [31:0] in_pc4, in_wdata4, out_pc4, out_wdata4;
    logic [4:0]  in_rd4, out_rd4;
    logic [3:0]  stall_cycles4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_regwrite(in_regwrite), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_regwrite(out_regwrite), .out_wdata(out_wdata), .out_rd(out_rd),
        .stall_cycles(stall_cycles)
    );

    pipe_stage_skid #(.SKID(0), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_pc(in_pc4),
        .in_regwrite(in_regwrite4), .in_wdata(in_wdata4), .in_rd(in_rd4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_pc(out_pc4),
        .out_regwrite(out_regwrite4), .out_wdata(out_wdata4), .out_rd(out_rd4),
        .stall_cycles(stall_cycles4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic rw,
                       input logic [31:0] wd, input logic [4:0] rd, input logic ordy);
        in_valid    = v;
        in_pc       = pc;
        in_regwrite = rw;
        in_wdata    = wd;
        in_rd       = rd;
        out_ready   = ordy;
    endtask

    initial begin
        rst = 1'b0;
        flush = $urandom_range(1);
        drv($urandom_range(1), $urandom, $urandom_range(1), $urandom, 5'($urandom), $urandom_range(1));
        flush4 = 1'b0; in_valid4 = 1'b0; in_pc4 = '0; in_regwrite4 = 1'b0;
        in_wdata4 = '0; in_rd4 = '0; out_ready4 = 1'b0;
        repeat (3) tick();
        chk("rst_pc", out_pc, 64'hffff_ffff);
        chk("rst_valid", out_valid, 0);
        chk("rst_regwrite", out_regwrite, 0);
        chk("rst_stall", stall_cycles, 0);
        rst = 1'b1;
        flush = 1'b0;
        drv(0, 0, 0, 0, 0, 1);
        tick();
        chk("rst_in_ready", in_ready, 1);

        // streaming
        drv(1, 32'h100, 1, 32'h11, 5'd1, 1);
        tick();
        chk("s0_pc", out_pc, 32'h100);
        chk("s0_valid", out_valid, 1);
        drv(1, 32'h104, 1, 32'h22, 5'd2, 1);
        tick();
        chk("s1_pc", out_pc, 32'h104);
        drv(1, 32'h108, 1, 32'h33, 5'd3, 1);
        tick();
        chk("s2_pc", out_pc, 32'h108);
        chk("s2_wdata", out_wdata, 32'h33);
        drv(0, 0, 0, 0, 0, 1);
        tick();
        chk("s_drain_valid", out_valid, 0);
        chk("s_stall", stall_cycles, 0);

        // back-pressure into the skid entry
        drv(1, 32'h200, 0, 0, 0, 0);
        tick();
        chk("bp0_pc", out_pc, 32'h200);
        chk("bp0_in_ready", in_ready, 1);
        drv(1, 32'h204, 0, 0, 0, 0);
        tick();
        chk("bp1_in_ready", in_ready, 0);
        chk("bp1_pc", out_pc, 32'h200);
        chk("bp1_stall", stall_cycles, 1);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        chk("bp2_stall", stall_cycles, 2);
        tick();
        chk("bp3_stall", stall_cycles, 3);
        chk("bp3_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        chk("bp4_pc", out_pc, 32'h204);
        chk("bp4_in_ready", in_ready, 1);
        tick();
        chk("bp5_valid", out_valid, 0);
        chk("bp5_stall", stall_cycles, 3);

        // flush while full, with an entry offered on the same cycle
        drv(1, 32'h210, 0, 0, 0, 0);
        tick();
        drv(1, 32'h214, 0, 0, 0, 0);
        tick();
        chk("fl_full_in_ready", in_ready, 0);
        chk("fl_pre_stall", stall_cycles, 4);
        flush = 1'b1;
        drv(1, 32'h300, 0, 0, 0, 1);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_pc", out_pc, 64'hffff_ffff);
        chk("fl_stall", stall_cycles, 4);
        chk("fl_in_ready", in_ready, 1);
        flush = 1'b0;
        drv(0, 0, 0, 0, 0, 1);
        tick();
        chk("fl_no300_valid", out_valid, 0);
        chk("fl_no300_pc", out_pc, 64'hffff_ffff);

        // x0 rule
        drv(1, 32'h400, 1, 32'hdead, 5'd0, 1);
        tick();
        chk("x0_regwrite", out_regwrite, 0);
        chk("x0_wdata", out_wdata, 32'hdead);
        chk("x0_rd", out_rd, 0);
        drv(1, 32'h404, 1, 32'hbeef, 5'd5, 1);
        tick();
        chk("x5_regwrite", out_regwrite, 1);
        chk("x5_rd", out_rd, 5);
        chk("x5_wdata", out_wdata, 32'hbeef);
        drv(0, 0, 0, 0, 0, 1);
        tick();
        chk("x_bubble_rd", out_rd, 0);

        // asynchronous reset while full
        drv(1, 32'h500, 1, 32'h5, 5'd7, 0);
        tick();
        drv(1, 32'h504, 1, 32'h6, 5'd8, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("ar_pre_stall", stall_cycles, 5);
        chk("ar_pre_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_pc", out_pc, 64'hffff_ffff);
        chk("ar_regwrite", out_regwrite, 0);
        chk("ar_stall", stall_cycles, 0);
        #1;
        rst = 1'b1;
        tick();
        chk("ar_in_ready", in_ready, 1);
        chk("ar_post_valid", out_valid, 0);

        // single-register variant: combinational ready, replace-in-place, 4-bit saturation
        in_valid4 = 1'b1; in_pc4 = 32'h600; out_ready4 = 1'b0;
        tick();
        chk("n0_pc", out_pc4, 32'h600);
        in_valid4 = 1'b0;
        #1;
        chk("n0_in_ready_stalled", in_ready4, 0);
        out_ready4 = 1'b1;
        #1;
        chk("n0_in_ready_comb", in_ready4, 1);
        out_ready4 = 1'b0;
        repeat (20) tick();
        chk("n_sat", stall_cycles4, 15);
        in_valid4 = 1'b1; in_pc4 = 32'h604; out_ready4 = 1'b1;
        tick();
        chk("n_replace_pc", out_pc4, 32'h604);
        in_valid4 = 1'b0;
        tick();
        chk("n_drain_valid", out_valid4, 0);
        chk("n_sat_hold", stall_cycles4, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
